// File: rtl/hmac_param_pkg.sv
// Shared constants and types for the HMAC register-bus feeder.
package hmac_param_pkg;

   // Byte addresses of the HMAC wrapper registers.
   localparam logic [31:0] HMAC_ADDR_CTRL   = 32'h0000_0008;
   localparam logic [31:0] HMAC_ADDR_STATUS = 32'h0000_000C;
   localparam logic [31:0] HMAC_ADDR_BLOCK0 = 32'h0000_0080;

   // CTRL register bit positions.
   localparam int HMAC_CTRL_INIT_BIT = 0;
   localparam int HMAC_CTRL_NEXT_BIT = 1;

   typedef enum logic [2:0] {
      FILL, PAD, LEN, WR_BLK, WR_CTRL, WAIT, POLL, DONE
   } feeder_state_e;

   // Keep the upper n bytes (n = 0..3), put the 0x80 marker at byte n and clear the rest.
   function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [2:0] n);
      logic [31:0] keep;
      keep     = ~(32'hFFFF_FFFF >> {n, 3'b000});
      pad_word = (data & keep) | (32'h0000_0080 << {(3'd3 - n), 3'b000});
   endfunction

endpackage

// File: rtl/hmac_block_feeder.sv
// Buffers a big-endian message into 1024-bit blocks, applies padding and the
// 128-bit length field, and pushes each block to the HMAC wrapper over a simple
// register bus, polling status between blocks.
module hmac_block_feeder
   import hmac_param_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  msg_valid,
   output logic                  msg_ready,
   input  logic [31:0]           msg_data,
   input  logic                  msg_last,
   input  logic [2:0]            msg_bytes,
   output logic                  hmac_cs,
   output logic                  hmac_we,
   output logic [ADDR_WIDTH-1:0] hmac_address,
   output logic [31:0]           hmac_write_data,
   input  logic [31:0]           hmac_read_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   feeder_state_e state_q, state_d;
   logic [31:0]   mem_q [32];
   logic [31:0]   mem_d [32];
   logic [4:0]    widx_q, widx_d;     // next fill slot
   logic [5:0]    pidx_q, pidx_d;     // next slot to clear while padding (may pass 31)
   logic [4:0]    wcnt_q, wcnt_d;     // block write index, wraps to 0 after each burst
   logic          wait_q, wait_d;
   logic [63:0]   bcnt_q, bcnt_d;     // message byte count
   logic          first_q, first_d;   // next block is the first of the message
   logic          final_q, final_d;   // last word has been taken in
   logic          extra_q, extra_d;   // length field spills into one more block
   logic          hipad_q, hipad_d;   // 0x80 marker belongs in word 0 of the extra block
   logic          busy_q, busy_d;
   logic          error_q, error_d;
   logic [31:0]   addr32;
   logic [63:0]   len_bits;
   logic          unused_bits;

   // Key block (1024 bits) is counted in the length.
   assign len_bits     = {bcnt_q[60:0], 3'b000} + 64'd1024;
   assign hmac_address = ADDR_WIDTH'(addr32);
   assign busy         = busy_q;
   assign error        = error_q;
   assign unused_bits  = ^{hmac_read_data[31:2], bcnt_q[63:61]};

   // Next-state, buffer updates and bus outputs.
   always_comb begin
      state_d = state_q;  mem_d   = mem_q;   widx_d  = widx_q;  pidx_d  = pidx_q;
      wcnt_d  = wcnt_q;   wait_d  = wait_q;  bcnt_d  = bcnt_q;  first_d = first_q;
      final_d = final_q;  extra_d = extra_q; hipad_d = hipad_q; busy_d  = busy_q;
      error_d = error_q;
      msg_ready       = 1'b0;
      hmac_cs         = 1'b0;
      hmac_we         = 1'b0;
      addr32          = '0;
      hmac_write_data = '0;
      done            = 1'b0;
      case (state_q)
         FILL: begin
            msg_ready = reset_n;
            if (msg_valid) begin
               if (msg_last && msg_bytes > 3'd4) begin
                  // malformed tail word: flag it and drop it
                  error_d = 1'b1;
               end else begin
                  error_d = 1'b0;
                  busy_d  = 1'b1;
                  if (!msg_last) begin
                     mem_d[widx_q] = msg_data;
                     bcnt_d        = bcnt_q + 64'd4;
                     widx_d        = widx_q + 5'd1;
                     if (widx_q == 5'd31) state_d = WR_BLK;
                  end else begin
                     final_d = 1'b1;
                     bcnt_d  = bcnt_q + 64'(msg_bytes);
                     state_d = PAD;
                     if (msg_bytes == 3'd4) begin
                        mem_d[widx_q] = msg_data;
                        if (widx_q != 5'd31) mem_d[widx_q + 5'd1] = 32'h8000_0000;
                        else                 hipad_d = 1'b1;
                        pidx_d = {1'b0, widx_q} + 6'd2;
                     end else begin
                        mem_d[widx_q] = pad_word(msg_data, msg_bytes);
                        pidx_d        = {1'b0, widx_q} + 6'd1;
                     end
                  end
               end
            end
         end
         PAD: begin
            pidx_d = pidx_q + 6'd1;
            if (pidx_q <= 6'd28) begin
               if (pidx_q < 6'd28) mem_d[pidx_q[4:0]] = '0;
               if (pidx_q >= 6'd27) state_d = LEN;
            end else begin
               if (pidx_q < 6'd32) mem_d[pidx_q[4:0]] = '0;
               if (pidx_q >= 6'd31) begin
                  extra_d = 1'b1;
                  state_d = WR_BLK;
               end
            end
         end
         LEN: begin
            mem_d[28] = '0;
            mem_d[29] = '0;
            mem_d[30] = len_bits[63:32];
            mem_d[31] = len_bits[31:0];
            state_d   = WR_BLK;
         end
         WR_BLK: begin
            hmac_cs         = 1'b1;
            hmac_we         = 1'b1;
            addr32          = HMAC_ADDR_BLOCK0 + {25'd0, wcnt_q, 2'b00};
            hmac_write_data = mem_q[wcnt_q];
            wcnt_d          = wcnt_q + 5'd1;
            if (wcnt_q == 5'd31) state_d = WR_CTRL;
         end
         WR_CTRL: begin
            hmac_cs         = 1'b1;
            hmac_we         = 1'b1;
            addr32          = HMAC_ADDR_CTRL;
            hmac_write_data = first_q ? (32'd1 << HMAC_CTRL_INIT_BIT) : (32'd1 << HMAC_CTRL_NEXT_BIT);
            first_d         = 1'b0;
            wait_d          = 1'b0;
            state_d         = WAIT;
         end
         WAIT: begin
            // status still shows the previous block for two cycles
            wait_d = 1'b1;
            if (wait_q) state_d = POLL;
         end
         POLL: begin
            hmac_cs = 1'b1;
            addr32  = HMAC_ADDR_STATUS;
            if (hmac_read_data[0]) begin
               if (extra_q) begin
                  for (int i = 0; i < 28; i++) mem_d[i] = '0;
                  if (hipad_q) mem_d[0] = 32'h8000_0000;
                  extra_d = 1'b0;
                  hipad_d = 1'b0;
                  state_d = LEN;
               end else if (!final_q) begin
                  widx_d  = '0;
                  state_d = FILL;
               end else if (hmac_read_data[1]) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            bcnt_d  = '0;
            widx_d  = '0;
            first_d = 1'b1;
            final_d = 1'b0;
            busy_d  = 1'b0;
            state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // State and buffer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FILL;
         mem_q   <= '{default: '0};
         widx_q  <= '0;
         pidx_q  <= '0;
         wcnt_q  <= '0;
         wait_q  <= 1'b0;
         bcnt_q  <= '0;
         first_q <= 1'b1;
         final_q <= 1'b0;
         extra_q <= 1'b0;
         hipad_q <= 1'b0;
         busy_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         widx_q  <= widx_d;
         pidx_q  <= pidx_d;
         wcnt_q  <= wcnt_d;
         wait_q  <= wait_d;
         bcnt_q  <= bcnt_d;
         first_q <= first_d;
         final_q <= final_d;
         extra_q <= extra_d;
         hipad_q <= hipad_d;
         busy_q  <= busy_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_hmac_block_feeder.sv
// Bench for hmac_block_feeder: random messages, a behavioural HMAC wrapper with
// status lag, and a padding reference built from the message bytes.
module tb_hmac_block_feeder;
   import hmac_param_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          msg_valid, msg_ready, msg_last;
   logic [31:0]   msg_data;
   logic [2:0]    msg_bytes;
   logic          hmac_cs, hmac_we;
   logic [AW-1:0] hmac_address;
   logic [31:0]   hmac_write_data, hmac_read_data;
   logic          busy, done, error;

   always #5 clk = ~clk;

   hmac_block_feeder #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
      .msg_last(msg_last), .msg_bytes(msg_bytes),
      .hmac_cs(hmac_cs), .hmac_we(hmac_we), .hmac_address(hmac_address),
      .hmac_write_data(hmac_write_data), .hmac_read_data(hmac_read_data),
      .busy(busy), .done(done), .error(error)
   );

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // stimulus
   logic [31:0] wq[$];
   logic        lq[$];
   logic [2:0]  bq[$];
   logic [7:0]  pre[$];
   int          wptr = 0;
   bit          hold = 0;
   bit          fresh_pick = 1;
   // reference and capture
   logic [31:0] exp_w[$];
   logic [31:0] cap_w[$];
   logic [31:0] ctrl_q[$];
   logic [31:0] cur_blk[32];
   int          cur_cnt = 0;
   // HMAC wrapper model
   int          lag_c = 0, eng_c = 0, tag_c = 0;
   logic        st_ready = 1'b1, st_tag = 1'b0;
   bit          last_poll_ok = 0;
   bit          exp_busy = 0, exp_err = 0, chk_busy = 1;
   int          done_cnt = 0;

   function automatic logic [31:0] capw(input int i);
      if (i < cap_w.size()) return cap_w[i];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] ctrlw(input int i);
      if (i < ctrl_q.size()) return ctrl_q[i];
      return 32'hxxxx_xxxx;
   endfunction

   // One clock: update the wrapper model, check the bus, then drive the next input.
   task automatic step();
      bit lagging, idle;
      @(negedge clk);
      lagging = (lag_c > 0);
      if (lag_c > 0) lag_c--;
      else if (eng_c > 0) begin eng_c--; st_ready = 1'b0; st_tag = 1'b0; end
      else begin
         st_ready = 1'b1;
         if (tag_c > 0) begin tag_c--; st_tag = 1'b0; end
         else st_tag = 1'b1;
      end
      idle = !lagging && st_ready;
      hmac_read_data = {30'd0, st_tag, st_ready};

      chk("rdy_vs_cs", msg_ready & hmac_cs, 0);
      chk("error", error, exp_err);
      if (chk_busy) chk("busy", busy, exp_busy);
      if (!hmac_cs) chk("bus_idle", {hmac_we, hmac_address, hmac_write_data}, 0);
      else if (hmac_we) begin
         chk("wr_engine_idle", idle, 1);
         if (hmac_address == AW'(HMAC_ADDR_CTRL)) begin
            chk("ctrl_after_32", cur_cnt, 32);
            ctrl_q.push_back(hmac_write_data);
            for (int i = 0; i < 32; i++) cap_w.push_back(cur_blk[i]);
            cur_cnt = 0;
            lag_c = 2;
            eng_c = $urandom_range(1, 8);
            tag_c = $urandom_range(0, 3);
         end else begin
            chk("blk_addr", hmac_address, AW'(HMAC_ADDR_BLOCK0) + AW'(4 * cur_cnt));
            cur_blk[cur_cnt % 32] = hmac_write_data;
            cur_cnt++;
         end
      end else begin
         chk("poll_addr", hmac_address, AW'(HMAC_ADDR_STATUS));
         last_poll_ok = idle && st_tag;
      end
      if (done) begin
         chk("done_after_tag", last_poll_ok, 1);
         done_cnt++;
         exp_busy = 0;
      end

      if (wptr < wq.size()) begin
         if (fresh_pick) msg_valid = hold || ($urandom_range(0, 3) != 0);
         msg_data  = wq[wptr];
         msg_last  = lq[wptr];
         msg_bytes = bq[wptr];
         if (msg_valid && msg_ready) begin
            exp_err = msg_last && (msg_bytes > 3'd4);
            if (!exp_err) exp_busy = 1;
            wptr++;
            fresh_pick = 1;
         end else fresh_pick = !msg_valid;
      end else begin
         msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = 3'd0; msg_data = 32'd0;
         fresh_pick = 1;
      end
   endtask

   // Build the word stream and the expected padded blocks for one message.
   task automatic load_msg(input int len, input bit zt);
      logic [7:0]  m[$];
      logic [7:0]  p[$];
      logic [31:0] w;
      logic [63:0] lb;
      int          nfull, r;
      if (pre.size() > 0) begin m = pre; len = m.size(); pre.delete(); end
      else for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      if (len == 0 || (zt && len % 4 == 0)) begin nfull = len / 4; r = 0; end
      else begin r = len % 4; if (r == 0) r = 4; nfull = (len - r) / 4; end
      wq.delete(); lq.delete(); bq.delete();
      for (int i = 0; i < nfull; i++) begin
         wq.push_back({m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]});
         lq.push_back(1'b0);
         bq.push_back(3'($urandom_range(0, 7)));
      end
      w = $urandom;
      for (int j = 0; j < r; j++) w[31-8*j -: 8] = m[4*nfull+j];
      wq.push_back(w); lq.push_back(1'b1); bq.push_back(3'(r));
      p = m;
      p.push_back(8'h80);
      while (p.size() % 128 != 112) p.push_back(8'h00);
      lb = 64'(1024 + 8 * len);
      for (int k = 0; k < 8; k++) p.push_back(8'h00);
      for (int k = 7; k >= 0; k--) p.push_back(lb[8*k +: 8]);
      exp_w.delete();
      for (int i = 0; i < p.size() / 4; i++) exp_w.push_back({p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
      wptr = 0; fresh_pick = 1;
      cap_w.delete(); ctrl_q.delete(); cur_cnt = 0;
   endtask

   task automatic run_msg(input int len, input bit h, input bit zt, input string tag);
      int d0;
      hold = h;
      load_msg(len, zt);
      d0 = done_cnt;
      for (int c = 0; c < 4000 && done_cnt == d0; c++) step();
      chk({tag, "_done"}, done_cnt, d0 + 1);
      chk({tag, "_nwords"}, cap_w.size(), exp_w.size());
      chk({tag, "_nctrl"}, ctrl_q.size(), exp_w.size() / 32);
      for (int i = 0; i < exp_w.size(); i++) chk({tag, "_word"}, capw(i), exp_w[i]);
      for (int b = 0; b < ctrl_q.size(); b++)
         chk({tag, "_ctrl"}, ctrl_q[b], (b == 0) ? (32'd1 << HMAC_CTRL_INIT_BIT) : (32'd1 << HMAC_CTRL_NEXT_BIT));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = 3'd0; msg_data = 32'd0;
      hmac_read_data = 32'd1;
      repeat (2) @(negedge clk);
      chk("rst_outs", {msg_ready, hmac_cs, hmac_we, hmac_address, hmac_write_data, busy, done, error}, '0);
      reset_n = 1'b1;
      step();
      chk("rdy_after_rst", msg_ready, 1);
      chk("busy_after_rst", busy, 0);

      run_msg(0, 0, 0, "empty");
      chk("empty_w0", capw(0), 32'h8000_0000);
      chk("empty_w30", capw(30), 32'h0);
      chk("empty_w31", capw(31), 32'h0000_0400);
      chk("empty_ctrl", ctrlw(0), 32'd1 << HMAC_CTRL_INIT_BIT);

      pre = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0, 0, "abc");
      chk("abc_w0", capw(0), 32'h6162_6380);
      chk("abc_w31", capw(31), 32'h0000_0418);

      run_msg(111, 0, 0, "l111");
      chk("l111_w27lo", capw(27) & 32'hFF, 32'h80);
      chk("l111_w31", capw(31), 32'h0000_0778);

      run_msg(112, 0, 0, "l112");
      chk("l112_w28", capw(28), 32'h8000_0000);
      chk("l112_b1w31", capw(63), 32'h0000_0780);
      chk("l112_ctrl1", ctrlw(1), 32'd1 << HMAC_CTRL_NEXT_BIT);

      run_msg(128, 1, 0, "l128");
      chk("l128_b1w0", capw(32), 32'h8000_0000);
      chk("l128_b1w31", capw(63), 32'h0000_0800);

      // reset in the middle of the second block burst
      hold = 1;
      load_msg(128, 0);
      for (int c = 0; c < 3000 && !(ctrl_q.size() == 1 && cur_cnt == 5); c++) step();
      chk("abort_reached", cur_cnt, 5);
      reset_n = 1'b0;
      #1;
      chk("abort_outs", {msg_ready, hmac_cs, hmac_we, hmac_address, hmac_write_data, busy, done, error}, '0);
      wq.delete(); lq.delete(); bq.delete(); wptr = 0;
      exp_busy = 0; exp_err = 0; cur_cnt = 0;
      repeat (4) step();
      reset_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step();
         chk("no_cs_after_rst", hmac_cs, 0);
      end
      pre = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0, 0, "post_rst");

      // malformed tail word
      chk_busy = 0;
      hold = 1;
      wq = '{32'hDEAD_BEEF}; lq = '{1'b1}; bq = '{3'd5}; wptr = 0; fresh_pick = 1;
      for (int c = 0; c < 20 && wptr < 1; c++) step();
      repeat (6) step();
      chk("err_held", error, 1);
      run_msg(20, 0, 0, "after_err");
      chk("err_cleared", error, 0);
      chk_busy = 1;

      for (int k = 0; k < 8; k++)
         run_msg($urandom_range(0, 300), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/hmac_block_feeder.md
HMAC_BLOCK_FEEDER -- requirements
Module: hmac_block_feeder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the width of the register-bus address it drives.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the port msg_valid, input, 1 bit: a message word is offered.
REQ-005 The block SHALL have the port msg_ready, output, 1 bit: the block accepts a word this cycle; transfer = msg_valid & msg_ready.
REQ-006 The block SHALL have the port msg_data, input, 32 bits: message word, big-endian, first byte in [31:24].
REQ-007 The block SHALL have the port msg_last, input, 1 bit: final word of the message.
REQ-008 The block SHALL have the port msg_bytes, input, 3 bits: number of valid upper bytes when msg_last=1 (0..4); ignored otherwise.
REQ-009 The block SHALL have the ports hmac_cs (1 bit), hmac_we (1 bit), hmac_address (ADDR_WIDTH bits) and hmac_write_data (32 bits), all outputs: register-bus master towards the HMAC wrapper.
REQ-010 The block SHALL have the port hmac_read_data, input, 32 bits: combinational read data returned in the same cycle as hmac_cs=1, hmac_we=0.
REQ-011 The block SHALL have the port busy, output, 1 bit: a message is in progress.
REQ-012 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the tag is valid.
REQ-013 The block SHALL have the port error, output, 1 bit: sticky; set when msg_last=1 and msg_bytes>4; cleared by the next accepted word.

Function
REQ-014 The block SHALL store accepted words into a 32x32 buffer at index widx (0..31) and keep a 64-bit byte counter; the 128-bit length field SHALL be {64'h0, (1024 + 8*bytes)} bits, with the 1024-bit key block included.
REQ-015 The FSM states SHALL be FILL, PAD, LEN, WR_BLK, WR_CTRL, WAIT, POLL and DONE; the reset state SHALL be FILL.
REQ-016 msg_ready SHALL be 1 only in FILL.
REQ-017 In FILL, a non-last word SHALL be stored and widx incremented; at widx=31 the FSM SHALL go to WR_BLK.
REQ-018 On the last word with n<4 bytes, the word SHALL be stored with byte n set to 0x80 and lower bytes zeroed; with n=4, the word SHALL be stored unchanged and 0x80000000 written at the next index; the FSM SHALL then go to PAD.
REQ-019 PAD SHALL zero one word per cycle; if the next free index is <=28, PAD SHALL zero up to index 27 and go to LEN; otherwise it SHALL zero to index 31, mark an extra block, and go to WR_BLK.
REQ-020 LEN SHALL write words 28..31 with the length in one cycle and go to WR_BLK.
REQ-021 WR_BLK SHALL issue 32 consecutive writes (cs=1, we=1), word i to HMAC_ADDR_BLOCK0+4*i, one per cycle, then go to WR_CTRL.
REQ-022 WR_CTRL SHALL issue one write to HMAC_ADDR_CTRL with the INIT bit for the first block of a message and the NEXT bit otherwise, then go to WAIT.
REQ-023 WAIT SHALL idle for exactly 2 cycles, which covers the ready-status lag, then go to POLL.
REQ-024 POLL SHALL read HMAC_ADDR_STATUS every cycle until bit0 (ready)=1.
REQ-025 On ready in POLL: a pending extra block SHALL go to LEN with words 0..27 zeroed; a non-final block SHALL go to FILL with widx=0; the final block SHALL go to DONE when bit1 (tag_valid)=1 and otherwise continue polling.
REQ-026 DONE SHALL pulse done for 1 cycle, clear the counters and first-block flag, and return to FILL.
REQ-027 busy SHALL be 1 from the first accepted word until the done pulse, inclusive.
REQ-028 hmac_cs SHALL be 0 outside WR_BLK, WR_CTRL and POLL; hmac_we, hmac_address and hmac_write_data SHALL be 0 whenever hmac_cs=0.
REQ-029 An empty message (msg_last=1, msg_bytes=0 on the first word) SHALL be legal.

Reset
REQ-030 reset_n low SHALL asynchronously force the FSM to FILL, widx and the byte counter to 0, the buffer to 0, and the first-block flag to 1.
REQ-031 While reset_n is low, the outputs msg_ready, hmac_cs, hmac_we, hmac_address, hmac_write_data, busy, done and error SHALL all be 0.
REQ-032 A reset asserted mid-message SHALL abandon the message with no further bus activity.

Structure
REQ-033 The address and bit constants (HMAC_ADDR_BLOCK0, HMAC_ADDR_CTRL, HMAC_ADDR_STATUS, HMAC_CTRL_INIT_BIT, HMAC_CTRL_NEXT_BIT) SHALL come from hmac_param_pkg.
REQ-034 The FSM state enum SHALL be added to hmac_param_pkg.
REQ-035 The block SHALL be a single module with no sub-module.

Verification
REQ-036 Empty message -> one block: word0=0x80000000, words1..30=0, word31=0x00000400; CTRL write with INIT; done after tag_valid.
REQ-037 "abc" (0x61626300, last, bytes=3) -> word0=0x61626380, word31=0x00000418; single INIT.
REQ-038 111 bytes (last word bytes=3) -> one block, 0x80 in word27[7:0], word31=0x00000778.
REQ-039 112 bytes (28 full words) -> two blocks: first with word28=0x80000000 and INIT; second zeros with word31=0x00000780 and NEXT.
REQ-040 128 bytes with msg_valid held high -> msg_ready low during WR_BLK through POLL; second block word0=0x80000000, word31=0x00000800, NEXT; reset asserted during the second WR_BLK -> all outputs 0 and no further cs.
REQ-041 msg_last with msg_bytes=5 -> error=1 and held until the next accepted word.
